dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single data memory (word-addressed, 4-bit byte-enable write type, 1-cycle registered read) between the core load/store path and a debug/loader port.
- Sits between the writeback-stage memory controller (core side) and the data memory; the debug port is driven by the debug/program-load unit.
- Fixed priority to the core, with a starvation counter that forces a debug grant after STARVE_MAX consecutive denied cycles.
- Generates the core stall and per-port read-response handshakes.

---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core has fixed priority, a starvation counter
// forces a debug grant, and a one-deep pipeline routes read responses to their owner.
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  input  logic [3:0]        c_wstrb,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wrType,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CORE = 2'd1,
    SEL_DBG  = 2'd2
  } sel_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       rsp_valid;
  owner_e     rsp_owner;
  sel_e       sel;
  logic       rd_grant;

  // Grant selection. Nothing is granted while reset is held, so a requester
  // cannot see an acceptance that the memory never performs.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    sel = SEL_NONE;
    if (rst_n) begin
      if (c_req && d_req)
        sel = (starve_cnt >= STARVE_LIM) ? SEL_DBG : SEL_CORE;
      else if (c_req)
        sel = SEL_CORE;
      else if (d_req)
        sel = SEL_DBG;
    end
  end

  assign c_gnt   = (sel == SEL_CORE);
  assign d_gnt   = (sel == SEL_DBG);
  assign c_stall = c_req & ~c_gnt;

  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    mem_wrType = 4'b0000;
    unique case (sel)
      SEL_CORE: begin
        mem_addr   = c_addr;
        mem_wdata  = c_wdata;
        mem_we     = c_we;
        mem_wrType = c_we ? c_wstrb : 4'b0000;
      end
      SEL_DBG: begin
        mem_addr   = d_addr;
        mem_wdata  = d_wdata;
        mem_we     = d_we;
        mem_wrType = d_we ? d_wstrb : 4'b0000;
      end
      default: ;
    endcase
  end

  assign rd_grant = (sel != SEL_NONE) && !mem_we;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      rsp_valid  <= 1'b0;
      rsp_owner  <= OWN_CORE;
    end else begin
      if (d_req && !d_gnt)
        starve_cnt <= (starve_cnt >= STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
      else
        starve_cnt <= '0;

      rsp_valid <= rd_grant;
      if (rd_grant)
        rsp_owner <= (sel == SEL_DBG) ? OWN_DBG : OWN_CORE;
    end
  end

  // Responses are masked while reset is asserted so a read granted just before
  // reset never surfaces as an rvalid.
  assign c_rvalid = rst_n & rsp_valid & (rsp_owner == OWN_CORE);
  assign d_rvalid = rst_n & rsp_valid & (rsp_owner == OWN_DBG);
  assign c_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: the driver checks grants and memory drive,
// a negedge monitor checks read responses against a scoreboard queue.
module tb_dmem_arbiter;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              c_req, c_we, d_req, d_we;
  logic [ADDR_W-1:0] c_addr, d_addr;
  logic [31:0]       c_wdata, d_wdata;
  logic [3:0]        c_wstrb, d_wstrb;
  logic              c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
  logic [31:0]       c_rdata, d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_wrType;
  logic              mem_we;

  typedef struct {
    logic        owner;  // 0 core, 1 debug
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wrType(mem_wrType),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, byte-enabled write.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wrType[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic owner, input logic [31:0] data);
    rsp_t r;
    r.owner = owner;
    r.data  = data;
    exp_q.push_back(r);
  endtask

  task automatic idle();
    c_req = 1'b0; d_req = 1'b0; c_we = 1'b0; d_we = 1'b0;
  endtask

  // Response monitor, decoupled from stimulus.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (c_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {30'd0, c_rvalid, d_rvalid}, 32'd0);
        end else begin
          r = exp_q.pop_front();
          check("rsp_owner", {30'd0, c_rvalid, d_rvalid}, r.owner ? 32'd1 : 32'd2);
          check("rsp_data", r.owner ? d_rdata : c_rdata, r.data);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'h0;
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h001] = 32'hA1A1A1A1;
    mem[12'h002] = 32'hB2B2B2B2;
    mem[12'h003] = 32'hC3C3C3C3;
    mem[12'h3FF] = 32'hFFFFFFFF;

    // Reset held with both ports requesting.
    rst_n = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h010; c_wdata = 32'h11111111; c_wstrb = 4'hF;
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'h055; d_wdata = 32'h22222222; d_wstrb = 4'hF;
    next_cycle();
    next_cycle();
    check("rst_c_gnt", c_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_wrtype", mem_wrType, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rvalid", {c_rvalid, d_rvalid}, 0);

    // First cycle after release: core wins.
    next_cycle();
    rst_n = 1'b1; d_we = 1'b0;
    #1;
    check("rel_c_gnt", c_gnt, 1);
    check("rel_d_gnt", d_gnt, 0);
    expect_rsp(1'b0, 32'hDEADBEEF);

    next_cycle(); idle(); #1;
    check("idle_mem_addr", mem_addr, 0);

    // Core read.
    next_cycle();
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h010; c_wstrb = 4'hF;
    #1;
    check("crd_gnt", c_gnt, 1);
    check("crd_stall", c_stall, 0);
    check("crd_addr", mem_addr, 32'h010);
    check("crd_we", mem_we, 0);
    check("crd_wrtype", mem_wrType, 0);
    expect_rsp(1'b0, 32'hDEADBEEF);
    next_cycle(); idle();

    // Debug write, no response follows.
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 12'h3FF; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
    #1;
    check("dwr_d_gnt", d_gnt, 1);
    check("dwr_c_gnt", c_gnt, 0);
    check("dwr_we", mem_we, 1);
    check("dwr_wrtype", mem_wrType, 4'b0011);
    check("dwr_wdata", mem_wdata, 32'h12345678);
    check("dwr_addr", mem_addr, 32'h3FF);
    next_cycle(); idle();
    next_cycle();
    // Read back: only the low two bytes were written.
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h3FF;
    #1;
    check("drd_gnt", d_gnt, 1);
    expect_rsp(1'b1, 32'hFFFF5678);
    next_cycle(); idle();
    next_cycle();

    // Starvation: both held, period 4 with debug in the fourth slot.
    c_req = 1'b1; c_we = 1'b0; c_addr = 12'h001;
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h002;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("stv_c_gnt", c_gnt, (i % 4) != 3);
      check("stv_d_gnt", d_gnt, (i % 4) == 3);
      check("stv_c_stall", c_stall, (i % 4) == 3);
      if ((i % 4) == 3) expect_rsp(1'b1, 32'hB2B2B2B2);
      else              expect_rsp(1'b0, 32'hA1A1A1A1);
      next_cycle();
    end
    idle();
    next_cycle();

    // Back-to-back reads core, debug, core.
    c_req = 1'b1; c_addr = 12'h001;
    #1; check("b2b0_c_gnt", c_gnt, 1); expect_rsp(1'b0, 32'hA1A1A1A1);
    next_cycle();
    c_req = 1'b0; d_req = 1'b1; d_addr = 12'h002;
    #1; check("b2b1_d_gnt", d_gnt, 1); expect_rsp(1'b1, 32'hB2B2B2B2);
    next_cycle();
    d_req = 1'b0; c_req = 1'b1; c_addr = 12'h003;
    #1; check("b2b2_c_gnt", c_gnt, 1); expect_rsp(1'b0, 32'hC3C3C3C3);
    next_cycle(); idle();
    next_cycle();

    // Reset mid-read: build up the counter, reset right after a read grant.
    c_req = 1'b1; c_addr = 12'h001; d_req = 1'b1; d_addr = 12'h002;
    #1; check("mid0_c_gnt", c_gnt, 1); expect_rsp(1'b0, 32'hA1A1A1A1);
    next_cycle();
    #1; check("mid1_c_gnt", c_gnt, 1);  // response to this read must be discarded
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", {c_gnt, d_gnt}, 0);
    check("mid_rst_rvalid", {c_rvalid, d_rvalid}, 0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("post_rst_d_gnt", d_gnt, i == 3);
      if (i == 3) expect_rsp(1'b1, 32'hB2B2B2B2);
      else        expect_rsp(1'b0, 32'hA1A1A1A1);
      next_cycle();
    end
    idle();
    next_cycle();
    next_cycle();
    check("rsp_pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
